// File: rtl/rns_compare_const_seq_9_8_7_if.sv
// Handshake and operand/result bundle for the sequential RNS (7,8,9) constant comparator.
// The optional bin_out member exists only when RNS_CMP_BIN_OUT_EN is defined.
interface rns_compare_const_seq_9_8_7_if;
    logic       in_valid_in;
    logic       in_ready_out;
    logic [2:0] a1_in;
    logic [2:0] a2_in;
    logic [3:0] a3_in;
    logic       out_valid_out;
    logic       out_ready_in;
    logic       res_le_out;
    logic       res_eq_out;
    logic       res_gr_out;
    logic       err_out;
`ifdef RNS_CMP_BIN_OUT_EN
    logic [8:0] bin_out;
`endif

    modport master (
        output in_valid_in, a1_in, a2_in, a3_in, out_ready_in,
        input  in_ready_out, out_valid_out, res_le_out, res_eq_out, res_gr_out, err_out
`ifdef RNS_CMP_BIN_OUT_EN
        , input bin_out
`endif
    );

    modport slave (
        input  in_valid_in, a1_in, a2_in, a3_in, out_ready_in,
        output in_ready_out, out_valid_out, res_le_out, res_eq_out, res_gr_out, err_out
`ifdef RNS_CMP_BIN_OUT_EN
        , output bin_out
`endif
    );
endinterface

// File: rtl/rns_compare_const_seq_9_8_7.sv
// Sequential comparator of an RNS (7,8,9) operand against CONST_VAL via mixed-radix digits.
// Define RNS_CMP_BIN_OUT_EN to also emit the reconstructed binary value on bin_out.
module rns_compare_const_seq_9_8_7 #(
    parameter int CONST_VAL = 10
) (
    input logic                          clk_in,
    input logic                          rst_in,
    rns_compare_const_seq_9_8_7_if.slave bus
);

    if (CONST_VAL < 0 || CONST_VAL > 503) begin : g_bad_const
        $error("CONST_VAL must lie in 0..503");
    end

    localparam logic [2:0] C1 = 3'(CONST_VAL % 7);
    localparam logic [2:0] C2 = 3'((CONST_VAL / 7) % 8);
    localparam logic [3:0] C3 = 4'(CONST_VAL / 56);
    localparam logic [9:0] CONST_DIGITS = {C3, C2, C1};

    typedef enum logic [2:0] {StIdle, StD2, StD3, StCmp, StOut} state_e;

    state_e     state_q, state_d;
    logic [2:0] a2_q;
    logic [3:0] a3_q;
    logic [2:0] d1_q, d2_q;
    logic [3:0] d3_q;
    logic       bad_q;
    logic       le_q, eq_q, gr_q, err_q;

    function automatic logic [3:0] mod9(input logic [6:0] x);
        return 4'(x % 7'd9);
    endfunction

    logic [2:0] d2_calc;
    logic [4:0] diff_a3;
    logic [3:0] diff_a3_m, scaled_m, diff_d2_m, d3_calc;
    logic [6:0] diff_d2;
    logic [9:0] digits;

    always_comb begin
        // (a2 - d1) * 7 mod 8: 3-bit wraparound does the modular reduction.
        d2_calc   = 3'((a2_q - d1_q) * 3'd7);
        diff_a3   = 5'(a3_q) + 5'd9 - 5'(d1_q);
        diff_a3_m = mod9(7'(diff_a3));
        scaled_m  = mod9(7'({diff_a3_m, 2'b00}));
        diff_d2   = 7'(scaled_m) + 7'd9 - 7'(d2_q);
        diff_d2_m = mod9(diff_d2);
        d3_calc   = mod9(7'({diff_d2_m, 3'b000}));
        digits    = {d3_q, d2_q, d1_q};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid_in) state_d = StD2;
            StD2:    state_d = StD3;
            StD3:    state_d = StCmp;
            StCmp:   state_d = StOut;
            StOut:   if (bus.out_ready_in) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

`ifdef RNS_CMP_BIN_OUT_EN
    logic [8:0] bin_q;
    logic [8:0] bin_calc;
    assign bin_calc = 9'(d1_q) + 9'(d2_q) * 9'd7 + 9'(d3_q) * 9'd56;
    assign bus.bin_out = bin_q;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            a2_q    <= '0;
            a3_q    <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            d3_q    <= '0;
            bad_q   <= 1'b0;
            le_q    <= 1'b0;
            eq_q    <= 1'b0;
            gr_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef RNS_CMP_BIN_OUT_EN
            bin_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (bus.in_valid_in) begin
                        a2_q  <= bus.a2_in;
                        a3_q  <= bus.a3_in;
                        d1_q  <= bus.a1_in;
                        bad_q <= (bus.a1_in == 3'd7) || (bus.a3_in >= 4'd9);
                    end
                end
                StD2: d2_q <= d2_calc;
                StD3: d3_q <= d3_calc;
                StCmp: begin
                    // Digit fields are non-overlapping, so a packed compare is lexicographic.
                    err_q <= bad_q;
                    le_q  <= !bad_q && (digits < CONST_DIGITS);
                    eq_q  <= !bad_q && (digits == CONST_DIGITS);
                    gr_q  <= !bad_q && (digits > CONST_DIGITS);
`ifdef RNS_CMP_BIN_OUT_EN
                    bin_q <= bad_q ? 9'd0 : bin_calc;
`endif
                end
                StOut: begin
                    if (bus.out_ready_in) begin
                        le_q  <= 1'b0;
                        eq_q  <= 1'b0;
                        gr_q  <= 1'b0;
                        err_q <= 1'b0;
`ifdef RNS_CMP_BIN_OUT_EN
                        bin_q <= '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready_out  = (state_q == StIdle);
    assign bus.out_valid_out = (state_q == StOut);
    assign bus.res_le_out    = le_q;
    assign bus.res_eq_out    = eq_q;
    assign bus.res_gr_out    = gr_q;
    assign bus.err_out       = err_q;

endmodule

// File: tb/tb_rns_compare_const_seq_9_8_7.sv
// Bench for rns_compare_const_seq_9_8_7: three instances (constants 10, 503, 0) share stimulus
// and are checked every cycle against a value-level model plus directed literal expectations.
module tb_rns_compare_const_seq_9_8_7;

    localparam logic [3:0] LE = 4'b0100;
    localparam logic [3:0] EQ = 4'b0010;
    localparam logic [3:0] GR = 4'b0001;
    localparam logic [3:0] ER = 4'b1000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rns_compare_const_seq_9_8_7_if if0 ();
    rns_compare_const_seq_9_8_7_if if1 ();
    rns_compare_const_seq_9_8_7_if if2 ();

    assign if1.in_valid_in  = if0.in_valid_in;
    assign if1.a1_in        = if0.a1_in;
    assign if1.a2_in        = if0.a2_in;
    assign if1.a3_in        = if0.a3_in;
    assign if1.out_ready_in = if0.out_ready_in;
    assign if2.in_valid_in  = if0.in_valid_in;
    assign if2.a1_in        = if0.a1_in;
    assign if2.a2_in        = if0.a2_in;
    assign if2.a3_in        = if0.a3_in;
    assign if2.out_ready_in = if0.out_ready_in;

    rns_compare_const_seq_9_8_7 #(.CONST_VAL(10))  dut0 (.clk_in(clk), .rst_in(rst), .bus(if0));
    rns_compare_const_seq_9_8_7 #(.CONST_VAL(503)) dut1 (.clk_in(clk), .rst_in(rst), .bus(if1));
    rns_compare_const_seq_9_8_7 #(.CONST_VAL(0))   dut2 (.clk_in(clk), .rst_in(rst), .bus(if2));

    // {in_ready, out_valid, err, le, eq, gr}
    logic [5:0] act [3];
    assign act[0] = {if0.in_ready_out, if0.out_valid_out, if0.err_out,
                     if0.res_le_out, if0.res_eq_out, if0.res_gr_out};
    assign act[1] = {if1.in_ready_out, if1.out_valid_out, if1.err_out,
                     if1.res_le_out, if1.res_eq_out, if1.res_gr_out};
    assign act[2] = {if2.in_ready_out, if2.out_valid_out, if2.err_out,
                     if2.res_le_out, if2.res_eq_out, if2.res_gr_out};
`ifdef RNS_CMP_BIN_OUT_EN
    logic [8:0] act_bin [3];
    assign act_bin[0] = if0.bin_out;
    assign act_bin[1] = if1.bin_out;
    assign act_bin[2] = if2.bin_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    function automatic int const_of(input int k);
        case (k)
            0:       return 10;
            1:       return 503;
            default: return 0;
        endcase
    endfunction

    // Chinese-remainder search: the unique X in 0..503 with the given residues.
    function automatic int crt(input int r1, input int r2, input int r3);
        for (int x = 0; x < 504; x++)
            if (x % 7 == r1 && x % 8 == r2 && x % 9 == r3) return x;
        return -1;
    endfunction

    function automatic logic [3:0] expect_res(input int r1, input int r2, input int r3,
                                              input int c);
        int x;
        if (r1 >= 7 || r3 >= 9) return ER;
        x = crt(r1, r2, r3);
        if (x < c) return LE;
        if (x == c) return EQ;
        return GR;
    endfunction

    function automatic int expect_bin(input int r1, input int r2, input int r3);
        if (r1 >= 7 || r3 >= 9) return 0;
        return crt(r1, r2, r3);
    endfunction

    // Transaction-level model: busy from accept, result visible from the 4th edge counting
    // the accepting edge, released by out_ready.
    logic       m_busy  [3];
    logic       m_valid [3];
    int         m_cnt   [3];
    logic [3:0] m_res   [3];
    int         m_bin   [3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_busy[k]  <= 1'b0;
                m_valid[k] <= 1'b0;
                m_cnt[k]   <= 0;
                m_res[k]   <= '0;
                m_bin[k]   <= 0;
            end else if (!m_busy[k]) begin
                if (if0.in_valid_in) begin
                    m_busy[k] <= 1'b1;
                    m_cnt[k]  <= 1;
                    m_res[k]  <= expect_res(int'(if0.a1_in), int'(if0.a2_in), int'(if0.a3_in),
                                            const_of(k));
                    m_bin[k]  <= expect_bin(int'(if0.a1_in), int'(if0.a2_in), int'(if0.a3_in));
                end
            end else if (!m_valid[k]) begin
                m_cnt[k] <= m_cnt[k] + 1;
                if (m_cnt[k] == 3) m_valid[k] <= 1'b1;
            end else if (if0.out_ready_in) begin
                m_busy[k]  <= 1'b0;
                m_valid[k] <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int actual, input int required);
        n_checks++;
        if (actual != required) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic cmp_all();
        logic [5:0] e;
        for (int k = 0; k < 3; k++) begin
            e = {!m_busy[k], m_valid[k], m_valid[k] ? m_res[k] : 4'b0000};
            chk($sformatf("model_dut%0d", k), int'(act[k]), int'(e));
`ifdef RNS_CMP_BIN_OUT_EN
            chk($sformatf("model_bin%0d", k), int'(act_bin[k]), m_valid[k] ? m_bin[k] : 0);
`endif
        end
    endtask

    // Compare at the falling edge, then advance one rising edge and settle.
    task automatic step();
        @(negedge clk);
        cmp_all();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a1, input int a2, input int a3,
                        input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2,
                        input int xb, input int hold);
        int n;
        if0.a1_in       = 3'(a1);
        if0.a2_in       = 3'(a2);
        if0.a3_in       = 4'(a3);
        if0.in_valid_in = 1'b1;
        step();
        if0.in_valid_in = 1'b0;
        if0.a1_in       = 3'($urandom);
        if0.a2_in       = 3'($urandom);
        if0.a3_in       = 4'($urandom);
        n = 1;
        while (!if0.out_valid_out && n < 12) begin
            step();
            n++;
        end
        chk("latency", n, 4);
        chk("res_c10", int'(act[0][3:0]), int'(e0));
        chk("res_c503", int'(act[1][3:0]), int'(e1));
        chk("res_c0", int'(act[2][3:0]), int'(e2));
`ifdef RNS_CMP_BIN_OUT_EN
        chk("bin_out", int'(act_bin[0]), xb);
`else
        if (xb < 0) $display("bad bin expectation %0d", xb);
`endif
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                if0.in_valid_in = 1'b1;
                step();
            end
            chk("hold_stable", int'(act[0]), int'({2'b01, e0}));
            if0.in_valid_in = 1'b0;
        end
        if0.out_ready_in = 1'b1;
        step();
        if0.out_ready_in = 1'b0;
        chk("release_idle", int'(act[0]), 6'b100000);
    endtask

    initial begin
        rst              = 1'b1;
        if0.in_valid_in  = 1'b0;
        if0.out_ready_in = 1'b0;
        if0.a1_in        = '0;
        if0.a2_in        = '0;
        if0.a3_in        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_c10", int'(act[0]), 6'b100000);
        chk("reset_c503", int'(act[1]), 6'b100000);
        chk("reset_c0", int'(act[2]), 6'b100000);
        chk("crt_10", crt(3, 2, 1), 10);
        chk("crt_9", crt(2, 1, 0), 9);
        chk("crt_11", crt(4, 3, 2), 11);
        chk("crt_503", crt(6, 7, 8), 503);
        rst = 1'b0;

        send(3, 2, 1, EQ, LE, GR, 10, 0);
        send(2, 1, 0, LE, LE, GR, 9, 0);
        send(4, 3, 2, GR, LE, GR, 11, 6);
        send(0, 0, 0, LE, LE, EQ, 0, 0);
        send(6, 7, 8, GR, EQ, GR, 503, 0);
        send(2, 4, 1, GR, LE, GR, 100, 0);
        send(7, 0, 0, ER, ER, ER, 0, 0);
        send(0, 0, 12, ER, ER, ER, 0, 2);

        // Abort an operand with reset while its third digit is being formed.
        if0.a1_in       = 3'd6;
        if0.a2_in       = 3'd7;
        if0.a3_in       = 4'd8;
        if0.in_valid_in = 1'b1;
        step();
        if0.in_valid_in = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_c10", int'(act[0]), 6'b100000);
        chk("abort_c503", int'(act[1]), 6'b100000);
        chk("abort_c0", int'(act[2]), 6'b100000);
        repeat (6) step();
        chk("abort_no_result", int'(if1.out_valid_out), 0);

        send(3, 2, 1, EQ, LE, GR, 10, 0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
